cpu_run_monitor: RTL
====================

# cpu_run_monitor

Synthesizable run-control and trace block attached to the multi-cycle MIPS CPU. It counts instruction fetches and keeps a ring buffer of the most recent PC/instruction pairs. It halts the CPU on a programmable fetch count or PC breakpoint, then streams the trace followed by a full register-file dump over a valid/ready port. It replaces fixed-cycle simulation stop logic with a parametrised block that also works on hardware.

## Interface
- TRACE_DEPTH, 16, ring-buffer entries; power of two, ≥2
- NUM_REGS, 32, register-file entries dumped
- CNT_W, 16, fetch-counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  one-cycle strobe, CPU fetched inst_i at pc_i
- pc_i  in  32  fetch PC
- inst_i  in  32  fetched instruction
- cfg_limit  in  CNT_W  stop after this many fetches; 0 = disabled
- cfg_break_en  in  1  enable PC breakpoint
- cfg_break_pc  in  32  breakpoint PC
- halt  out  1  stalls CPU, registered
- stop_cause  out  2  bit0 count limit, bit1 breakpoint
- rf_raddr  out  5  register-file read address
- rf_rdata  in  32  asynchronous read data for rf_raddr
- out_valid  out  1  stream beat valid
- out_ready  in  1  sink accepts beat
- out_tag  out  2  0 = PC, 1 = INST, 2 = REG
- out_data  out  32  beat payload
- done  out  1  dump complete, sticky until rst

## Operation
- States: RUN, DRAIN, DUMP, DONE. Reset enters RUN.
- RUN: on fetch_en, write {pc_i, inst_i} to ring at wr_ptr; wr_ptr wraps mod TRACE_DEPTH. Entry count saturates at TRACE_DEPTH, so the oldest entry is overwritten. fetch_cnt increments and saturates at all-ones.
- Count trigger: fetch_en while cfg_limit≠0 and fetch_cnt+1 == cfg_limit. Break trigger: fetch_en while cfg_break_en and pc_i == cfg_break_pc.
- Any trigger → halt=1, stop_cause ← {break, count}, which may be 2'b11; go to DRAIN. The triggering fetch is recorded.
- DRAIN: emit entries oldest-first, starting at (wr_ptr − count) mod DEPTH. Each entry is two beats: tag 0 with the PC, then tag 1 with the instruction. After the last entry go to DUMP.
- DUMP: rf_raddr steps 0..NUM_REGS−1. Each register gives one tag-2 beat with out_data = rf_rdata; register 0 is forced to 0. After the last beat is accepted go to DONE.
- DONE: done=1, halt=1, out_valid=0. Held until rst.
- fetch_en outside RUN is ignored.
- Handshake: a beat transfers when out_valid && out_ready. While out_valid=1 and out_ready=0, out_tag, out_data and rf_raddr are held stable and out_valid stays high.

## Timing
- Reset values: halt 0, stop_cause 0, done 0, out_valid 0, out_tag 0, out_data 0, rf_raddr 0. Pointers, counters and entry count are 0.
- halt rises the cycle after the triggering fetch_en.
- First out_valid is asserted the cycle after halt rises.
- With out_ready held at 1: one beat per cycle, 2·entries + NUM_REGS beats in total.
- done rises the cycle after the final register beat is accepted.
- rst at any cycle, including mid-DRAIN or mid-DUMP: the next cycle shows all reset values. A partial stream is abandoned, with no further beats.
- cfg_* inputs are sampled on each fetch and must be stable during RUN.

## Structure
- Shared package run_monitor_pkg holds:
  - state encoding
  - tag constants TAG_PC=0, TAG_INST=1, TAG_REG=2
  - cause bit positions
- Sub-module trace_ring: TRACE_DEPTH×64 buffer with one write port and one asynchronous read port. It keeps wr_ptr and the entry count, and provides the oldest-index calculation.
- cpu_run_monitor holds the FSM, fetch counter, triggers and stream output register.

## Test plan
- Count stop: cfg_limit=30, break off, 30 fetches at PC 0x3000+4k. Required response:
  - halt=1 after the 30th fetch, cause=01
  - 16 trace entries, PCs 0x3038..0x3074 in order
  - then 32 REG beats with r0=0
  - then done=1
- Breakpoint: limit=100, break_pc=0x3010 → halt after the 5th fetch, cause=10, 5 entries 0x3000..0x3010, then the register dump.
- Simultaneous: limit=5, break_pc=0x3010 → cause=11, 5 entries.
- Backpressure: scenario 1 with out_ready random 50% → identical beat sequence, no loss or duplication, payload stable while stalled.
- Reset mid-operation: assert rst during the 10th DUMP beat → all outputs 0 next cycle. A new run with limit=3 then yields a 3-entry trace.
- Disabled/wrap: limit=0, break off, 1000 fetches → halt stays 0. Then enable break at the next PC → 16 entries, last one the break PC.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// Shared encodings for the CPU run monitor: FSM states, stream tags and stop-cause bits.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDump  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] TAG_PC   = 2'd0;
    localparam logic [1:0] TAG_INST = 2'd1;
    localparam logic [1:0] TAG_REG  = 2'd2;

    localparam int unsigned CAUSE_COUNT = 0;
    localparam int unsigned CAUSE_BREAK = 1;

endpackage

// File: rtl/trace_ring.sv
// Circular PC/instruction trace buffer; reads are addressed as an offset from the oldest entry.
module trace_ring #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic [63:0]                wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_off_i,
    output logic [63:0]                rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (we_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (count_q != (AW+1)'(DEPTH)) begin
                count_q <= count_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_i && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // A full ring truncates count to 0, making the oldest entry the next write slot.
    assign oldest    = wr_ptr_q - count_q[AW-1:0];
    assign rd_idx    = oldest + rd_off_i;
    assign rd_data_o = mem_q[rd_idx];
    assign count_o   = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run control for the multi-cycle CPU: counts fetches, halts on limit or breakpoint,
// then streams the fetch trace and a register-file dump over a valid/ready port.
module cpu_run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             cfg_break_en,
    input  logic [31:0]      cfg_break_pc,
    output logic             halt,
    output logic [1:0]       stop_cause,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_tag,
    output logic [31:0]      out_data,
    output logic             done
);
    localparam int unsigned AW      = $clog2(TRACE_DEPTH);
    localparam logic [4:0]  LastReg = 5'(NUM_REGS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [AW:0]      rd_cnt_q;
    logic             half_q;
    logic             halt_q;
    logic             done_q;
    logic             out_valid_q;
    logic [1:0]       stop_cause_q;
    logic [1:0]       out_tag_q;
    logic [31:0]      out_data_q;
    logic [4:0]       rf_raddr_q;

    logic [63:0]      rd_data;
    logic [AW:0]      entry_cnt;
    logic             fetch_run;
    logic             count_hit;
    logic             break_hit;
    logic             advance;

    assign fetch_run = fetch_en && (state_q == StRun);
    // Widened compare so a saturated counter can never alias onto a small limit.
    assign count_hit = fetch_run && (cfg_limit != '0) &&
                       (({1'b0, fetch_cnt_q} + (CNT_W+1)'(1)) == {1'b0, cfg_limit});
    assign break_hit = fetch_run && cfg_break_en && (pc_i == cfg_break_pc);
    assign advance   = !out_valid_q || out_ready;

    trace_ring #(
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .we_i      (fetch_run),
        .wdata_i   ({pc_i, inst_i}),
        .rd_off_i  (rd_cnt_q[AW-1:0]),
        .rd_data_o (rd_data),
        .count_o   (entry_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            fetch_cnt_q  <= '0;
            rd_cnt_q     <= '0;
            half_q       <= 1'b0;
            halt_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            stop_cause_q <= '0;
            out_tag_q    <= TAG_PC;
            out_data_q   <= '0;
            rf_raddr_q   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (fetch_en) begin
                        if (fetch_cnt_q != '1) begin
                            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
                        end
                        if (count_hit || break_hit) begin
                            halt_q                    <= 1'b1;
                            stop_cause_q[CAUSE_COUNT] <= count_hit;
                            stop_cause_q[CAUSE_BREAK] <= break_hit;
                            state_q                   <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (advance) begin
                        out_valid_q <= 1'b1;
                        if (rd_cnt_q != entry_cnt) begin
                            out_tag_q  <= half_q ? TAG_INST : TAG_PC;
                            out_data_q <= half_q ? rd_data[31:0] : rd_data[63:32];
                            half_q     <= !half_q;
                            if (half_q) begin
                                rd_cnt_q <= rd_cnt_q + (AW+1)'(1);
                            end
                        end else begin
                            out_tag_q  <= TAG_REG;
                            out_data_q <= '0;
                            rf_raddr_q <= '0;
                            state_q    <= StDump;
                        end
                    end
                end
                StDump: begin
                    if (out_ready) begin
                        if (rf_raddr_q == LastReg) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            rf_raddr_q <= rf_raddr_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Register beats pass the asynchronous register-file read straight through.
    assign out_data   = (out_tag_q == TAG_REG) ? ((rf_raddr_q == '0) ? '0 : rf_rdata)
                                               : out_data_q;
    assign halt       = halt_q;
    assign stop_cause = stop_cause_q;
    assign rf_raddr   = rf_raddr_q;
    assign out_valid  = out_valid_q;
    assign out_tag    = out_tag_q;
    assign done       = done_q;

endmodule
